tlk2711_tx_test_gen: RTL

//  Test-mode frame generator for the TLK2711 TX parallel interface (link check).

---
 rtl/tlk2711_pkg.sv | 60 ++++++
 rtl/tlk2711_tx_test_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link-test definitions: K/D code bytes, framing words and the
// frame-state encoding used by both the TX generator and the RX validation checker.
package tlk2711_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K29_7 = 8'hFD;

  localparam logic [15:0] HEAD_0    = 16'hEB90;
  localparam logic [15:0] HEAD_1    = 16'hE116;
  localparam logic [15:0] SYNC_WORD = {D5_6, K28_5};
  localparam logic [15:0] SOF_WORD  = {K28_2, K27_7};
  localparam logic [15:0] EOF_WORD  = {K29_7, K30_7};

  typedef enum logic [3:0] {
    FS_IDLE    = 4'd0,
    FS_SYNC    = 4'd1,
    FS_SOF     = 4'd2,
    FS_HOF0    = 4'd3,
    FS_HOF1    = 4'd4,
    FS_FILEEND = 4'd5,
    FS_FCNT    = 4'd6,
    FS_LEN     = 4'd7,
    FS_DATA    = 4'd8,
    FS_CHKSUM  = 4'd9,
    FS_EOF     = 4'd10
  } frame_state_e;

  // Plain-vector views of the enum so the state register can hold illegal codes
  localparam logic [3:0] ST_IDLE    = FS_IDLE;
  localparam logic [3:0] ST_SYNC    = FS_SYNC;
  localparam logic [3:0] ST_SOF     = FS_SOF;
  localparam logic [3:0] ST_HOF0    = FS_HOF0;
  localparam logic [3:0] ST_HOF1    = FS_HOF1;
  localparam logic [3:0] ST_FILEEND = FS_FILEEND;
  localparam logic [3:0] ST_FCNT    = FS_FCNT;
  localparam logic [3:0] ST_LEN     = FS_LEN;
  localparam logic [3:0] ST_DATA    = FS_DATA;
  localparam logic [3:0] ST_CHKSUM  = FS_CHKSUM;
  localparam logic [3:0] ST_EOF     = FS_EOF;

  typedef struct packed {
    logic        tkmsb;
    logic        tklsb;
    logic [15:0] txd;
  } tx_word_t;

  function automatic tx_word_t make_word(input logic tkmsb, input logic tklsb,
                                         input logic [15:0] txd);
    tx_word_t w;
    w.tkmsb = tkmsb;
    w.tklsb = tklsb;
    w.txd   = txd;
    return w;
  endfunction

endpackage

// File: rtl/tlk2711_tx_test_gen.sv
// TLK2711 TX test-mode frame generator: sync gap, SOF, headers, file-end flag,
// frame count, length, incrementing payload, checksum, EOF. All pins registered.
module tlk2711_tx_test_gen
  import tlk2711_pkg::*;
#(
  parameter int DATAWIDTH       = 16,
  parameter int SYNC_GAP        = 16,
  parameter int FRAMES_PER_FILE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_soft_rst,
  input  logic                 i_tx_start_test,
  input  logic [15:0]          i_tx_length,
  output logic                 o_2711_tkmsb,
  output logic                 o_2711_tklsb,
  output logic [DATAWIDTH-1:0] o_2711_txd,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [15:0]          o_frame_cnt
);

  localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;

  logic [3:0]       cs;
  logic [3:0]       ns;
  logic [GAP_W-1:0] gap_cnt;
  logic [14:0]      len_w;
  logic [15:0]      word_idx;
  logic [15:0]      sum;
  logic [15:0]      frame_cnt;

  logic     gap_last;
  logic     data_last;
  logic     last_frame;
  logic     busy_nxt;
  tx_word_t word_nxt;
  logic     unused_len_lsb;

  assign gap_last       = (gap_cnt == GAP_W'(SYNC_GAP - 1));
  assign data_last      = (word_idx == ({1'b0, len_w} - 16'd1));
  assign last_frame     = (frame_cnt == 16'(FRAMES_PER_FILE - 1));
  // Payload is counted in whole words, so an odd byte count simply rounds down
  assign unused_len_lsb = i_tx_length[0];
  assign o_frame_cnt    = frame_cnt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    ns       = cs;
    word_nxt = make_word(1'b0, 1'b1, SYNC_WORD);
    busy_nxt = 1'b0;
    case (cs)
      ST_IDLE: begin
        if (i_tx_start_test) ns = ST_SYNC;
      end
      ST_SYNC: begin
        if (gap_last) ns = i_tx_start_test ? ST_SOF : ST_IDLE;
      end
      ST_SOF: begin
        word_nxt = make_word(1'b1, 1'b1, SOF_WORD);
        busy_nxt = 1'b1;
        ns       = ST_HOF0;
      end
      ST_HOF0: begin
        word_nxt = make_word(1'b0, 1'b0, HEAD_0);
        busy_nxt = 1'b1;
        ns       = ST_HOF1;
      end
      ST_HOF1: begin
        word_nxt = make_word(1'b0, 1'b0, HEAD_1);
        busy_nxt = 1'b1;
        ns       = ST_FILEEND;
      end
      ST_FILEEND: begin
        word_nxt = make_word(1'b0, 1'b0, {15'd0, last_frame});
        busy_nxt = 1'b1;
        ns       = ST_FCNT;
      end
      ST_FCNT: begin
        word_nxt = make_word(1'b0, 1'b0, frame_cnt);
        busy_nxt = 1'b1;
        ns       = ST_LEN;
      end
      ST_LEN: begin
        word_nxt = make_word(1'b0, 1'b0, {len_w, 1'b0});
        busy_nxt = 1'b1;
        ns       = ST_DATA;
      end
      ST_DATA: begin
        word_nxt = make_word(1'b0, 1'b0, word_idx);
        busy_nxt = 1'b1;
        if (data_last) ns = ST_CHKSUM;
      end
      ST_CHKSUM: begin
        word_nxt = make_word(1'b0, 1'b0, sum);
        busy_nxt = 1'b1;
        ns       = ST_EOF;
      end
      ST_EOF: begin
        word_nxt = make_word(1'b1, 1'b1, EOF_WORD);
        busy_nxt = 1'b1;
        ns       = ST_SYNC;
      end
      default: ns = ST_IDLE;
    endcase
  end

  // NOTE: state and pin registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs           <= ST_IDLE;
      gap_cnt      <= '0;
      len_w        <= 15'd1;
      word_idx     <= '0;
      sum          <= '0;
      frame_cnt    <= '0;
      o_2711_tkmsb <= 1'b0;
      o_2711_tklsb <= 1'b1;
      o_2711_txd   <= SYNC_WORD;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (i_soft_rst) begin
      cs           <= ST_IDLE;
      gap_cnt      <= '0;
      len_w        <= 15'd1;
      word_idx     <= '0;
      sum          <= '0;
      frame_cnt    <= '0;
      o_2711_tkmsb <= 1'b0;
      o_2711_tklsb <= 1'b1;
      o_2711_txd   <= SYNC_WORD;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      cs      <= ns;
      gap_cnt <= (cs == ST_SYNC && !gap_last) ? gap_cnt + GAP_W'(1) : '0;

      // Length is captured once per frame; later changes wait for the next SOF
      if (cs == ST_SOF) begin
        len_w    <= (i_tx_length[15:1] == 15'd0) ? 15'd1 : i_tx_length[15:1];
        word_idx <= '0;
        sum      <= '0;
      end else if (cs == ST_DATA) begin
        word_idx <= word_idx + 16'd1;
        sum      <= sum + word_idx;
      end

      if (cs == ST_EOF) frame_cnt <= last_frame ? 16'd0 : frame_cnt + 16'd1;

      o_2711_tkmsb <= word_nxt.tkmsb;
      o_2711_tklsb <= word_nxt.tklsb;
      o_2711_txd   <= word_nxt.txd;
      o_busy       <= busy_nxt;
      o_frame_done <= (cs == ST_EOF);
    end
  end

endmodule
